// File: rtl/mem_bus_initiator_pkg.sv
// Shared encodings for the MEM-stage bus initiator: access sizes, FSM states,
// the read-data value returned on a bus timeout, and the alignment rule.
package mem_bus_pkg;

  // Access size encodings; 2'd3 is treated as a word everywhere
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Initiator FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Returned as load data when a request times out on the bus
  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

  // Bytes can never be misaligned; halves need addr[0]=0; words need addr[1:0]=0
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_bus_initiator_lane_align.sv
// Combinational byte-lane steering for a 32-bit bus: replicates store data
// across lanes and builds byte enables, and extracts/extends load data
// from the raw bus word according to the low address bits.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] store_data,
  input  logic [31:0] raw_rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_be,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Per-lane enable and write data: byte stores hit one lane, halves hit a lane pair
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_be[gi] = (size == SZ_BYTE) ? (addr_lo == LANE) :
                         (size == SZ_HALF) ? (addr_lo[1] == LANE[1]) : 1'b1;
    assign lane_wdata[8*gi +: 8] = (size == SZ_BYTE) ? store_data[7:0] :
                                   (size == SZ_HALF) ? store_data[8*(gi%2) +: 8] :
                                                       store_data[8*gi +: 8];
  end

  // Select the addressed byte/half and extend it to 32 bits
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = raw_rdata[7:0];
      2'd1:    byte_sel = raw_rdata[15:8];
      2'd2:    byte_sel = raw_rdata[23:16];
      default: byte_sel = raw_rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? raw_rdata[31:16] : raw_rdata[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
      default: load_data = raw_rdata;
    endcase
  end

endmodule

// File: rtl/mem_bus_initiator.sv
// MEM-stage load/store initiator on a variable-latency req/ack bus.
// Accepts one op per handshake, holds bus_* stable until bus_ack, and
// returns a one-cycle rsp_valid pulse with extended load data.
// Optional build macro MEM_TIMEOUT_EN: abandon a request after TIMEOUT
// cycles in REQ and complete it with err=1 and rsp_rdata=32'hDEADBEEF.
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  logic [1:0]        state_reg;
  logic [1:0]        size_reg;
  logic [1:0]        addr_lo_reg;
  logic              signed_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              err_reg;
  logic              bus_req_reg;
  logic              bus_we_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [DATA_W-1:0] bus_wdata_reg;
  logic [3:0]        bus_be_reg;

  logic [1:0]        op_size;
  logic [1:0]        op_addr_lo;
  logic              op_signed;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_be;
  logic [31:0]       load_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] timeout_cnt_reg;
`endif

  // While idle the aligner sees the incoming request (store lanes);
  // afterwards it sees the latched op (load extraction at ack time).
  assign op_size    = (state_reg == ST_IDLE) ? req_size      : size_reg;
  assign op_addr_lo = (state_reg == ST_IDLE) ? req_addr[1:0] : addr_lo_reg;
  assign op_signed  = (state_reg == ST_IDLE) ? req_signed    : signed_reg;

  mem_lane_align u_align (
    .size       (op_size),
    .addr_lo    (op_addr_lo),
    .is_signed  (op_signed),
    .store_data (req_wdata),
    .raw_rdata  (bus_rdata),
    .lane_wdata (lane_wdata),
    .lane_be    (lane_be),
    .load_data  (load_data)
  );

  // The pipeline holds until the op's completion cycle
  assign stall = req_valid & (state_reg != ST_DONE);

  // FSM plus all registered bus and response outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      size_reg      <= SZ_BYTE;
      addr_lo_reg   <= 2'd0;
      signed_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      err_reg       <= 1'b0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_be_reg    <= 4'b0000;
`ifdef MEM_TIMEOUT_EN
      timeout_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            if (is_misaligned(req_size, req_addr[1:0])) begin
              // Misaligned ops complete with an error and never reach the bus
              state_reg     <= ST_DONE;
              rsp_valid_reg <= 1'b1;
              err_reg       <= 1'b1;
              rsp_rdata_reg <= '0;
            end else begin
              state_reg     <= ST_REQ;
              size_reg      <= req_size;
              addr_lo_reg   <= req_addr[1:0];
              signed_reg    <= req_signed;
              bus_req_reg   <= 1'b1;
              bus_we_reg    <= req_write;
              bus_addr_reg  <= {req_addr[ADDR_W-1:2], 2'b00};
              bus_wdata_reg <= lane_wdata;
              bus_be_reg    <= lane_be;
`ifdef MEM_TIMEOUT_EN
              timeout_cnt_reg <= '0;
`endif
            end
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            state_reg     <= ST_DONE;
            bus_req_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            err_reg       <= 1'b0;
            rsp_rdata_reg <= bus_we_reg ? '0 : load_data;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_cnt_reg == CNT_LAST) begin
            state_reg       <= ST_DONE;
            bus_req_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            err_reg         <= 1'b1;
            rsp_rdata_reg   <= ERR_RDATA;
            timeout_cnt_reg <= '0;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          state_reg     <= ST_IDLE;
          rsp_valid_reg <= 1'b0;
          err_reg       <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign err       = err_reg;
  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign bus_be    = bus_be_reg;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Testbench for mem_bus_initiator: a table of directed vectors, hand-written
// reset/spurious-ack/timeout sequences, and random ops checked against an
// arithmetic model of the lane, alignment and extension rules.
module tb_mem_bus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, err, bus_req, bus_we, bus_ack;
  logic [31:0] rsp_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] raw;
    int          dly;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t vecs[11];

  mem_bus_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .err        (err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: expected lanes/result from size, offset and raw data
  function automatic vec_t make_vec(input logic wr, input logic [1:0] sz, input logic sg,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    input logic [31:0] raw, input int dly);
    vec_t r;
    int nb, off;
    longint one, v;
    one = 1;
    off = int'(addr % 4);
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    r.wr = wr; r.sz = sz; r.sg = sg; r.addr = addr; r.wd = wd; r.raw = raw; r.dly = dly;
    r.eerr = (off % nb) != 0;
    r.be = 4'(((1 << nb) - 1) << off);
    if (nb == 1)      r.ewd = (wd & 32'hFF) * 32'h0101_0101;
    else if (nb == 2) r.ewd = (wd & 32'hFFFF) * 32'h0001_0001;
    else              r.ewd = wd;
    v = longint'(raw >> (8 * off)) & ((one << (8 * nb)) - 1);
    if (sg && nb < 4 && v >= (one << (8 * nb - 1))) v = v - (one << (8 * nb));
    r.erd = (wr || r.eerr) ? 32'h0 : 32'(v);
    return r;
  endfunction

  // Present one op at a negedge in IDLE and follow it to completion
  task automatic run_op(input vec_t v, input string tag);
    req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_signed = v.sg;
    req_addr = v.addr; req_wdata = v.wd;
    #1;
    chk({tag, " stall_at_accept"}, 32'(stall), 32'd1);
    @(negedge clk);
    if (v.eerr) begin
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " err"}, 32'(err), 32'd1);
      chk({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
      chk({tag, " no_bus_req"}, 32'(bus_req), 32'd0);
      chk({tag, " stall_done"}, 32'(stall), 32'd0);
    end else begin
      chk({tag, " bus_req"}, 32'(bus_req), 32'd1);
      chk({tag, " bus_we"}, 32'(bus_we), 32'(v.wr));
      chk({tag, " bus_addr"}, bus_addr, v.addr & ~32'h3);
      chk({tag, " bus_be"}, 32'(bus_be), 32'(v.be));
      if (v.wr) chk({tag, " bus_wdata"}, bus_wdata, v.ewd);
      // Request inputs may wander while stalled; the latched op must not move
      req_addr = $urandom; req_size = 2'($urandom); req_wdata = $urandom;
      req_write = 1'($urandom); req_signed = 1'($urandom);
      for (int n = 0; n < v.dly; n++) begin
        @(negedge clk);
        chk({tag, " hold_bus_req"}, 32'(bus_req), 32'd1);
        chk({tag, " hold_stall"}, 32'(stall), 32'd1);
        chk({tag, " hold_addr"}, bus_addr, v.addr & ~32'h3);
        chk({tag, " no_early_rsp"}, 32'(rsp_valid), 32'd0);
      end
      bus_ack = 1'b1; bus_rdata = v.raw;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = $urandom;
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " err"}, 32'(err), 32'd0);
      chk({tag, " rsp_rdata"}, rsp_rdata, v.erd);
      chk({tag, " bus_req_drop"}, 32'(bus_req), 32'd0);
      chk({tag, " stall_done"}, 32'(stall), 32'd0);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk({tag, " rsp_pulse_end"}, 32'(rsp_valid), 32'd0);
    $display("%s wr=%0d sz=%0d sg=%0d addr=%h wd=%h raw=%h dly=%0d -> rdata=%h",
             tag, v.wr, v.sz, v.sg, v.addr, v.wd, v.raw, v.dly, v.erd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen_rsp;
    vec_t rv;

    // Directed vectors: expected values written out by hand
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'h8000_00F0, 2, 4'b1111, 32'h0, 32'h8000_00F0, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h8012_3456, 1, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 4'b1000, 32'h0, 32'h0000_0080, 1'b0};
    vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 1, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0105, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 3, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
    vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0301, 32'hAAAA_0055, 32'h0, 2, 4'b0010, 32'h5555_5555, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 2'd3, 1'b1, 32'h0000_0040, 32'h0, 32'h1234_5678, 1, 4'b1111, 32'h0, 32'h1234_5678, 1'b0};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 32'h0000_0000, 32'h0, 32'hFFFF_FF7F, 1, 4'b0001, 32'h0, 32'h0000_007F, 1'b0};

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("reset bus_req", 32'(bus_req), 32'd0);
    chk("reset bus_we", 32'(bus_we), 32'd0);
    chk("reset bus_be", 32'(bus_be), 32'd0);
    chk("reset bus_addr", bus_addr, 32'h0);
    chk("reset bus_wdata", bus_wdata, 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // A bus_ack while idle must not produce a response
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("idle_ack rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ack bus_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    chk("idle_ack rsp_valid_later", 32'(rsp_valid), 32'd0);
    $display("idle_ack: spurious ack applied in IDLE");

    // Reset while in REQ aborts the op; the later ack is ignored
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h0000_0400;
    @(negedge clk);
    chk("rst_req bus_req_before", 32'(bus_req), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    chk("rst_req bus_req_after", 32'(bus_req), 32'd0);
    chk("rst_req rsp_valid_after", 32'(rsp_valid), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("rst_req late_ack rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rst_req late_ack rsp_valid2", 32'(rsp_valid), 32'd0);
    chk("rst_req bus_req_idle", 32'(bus_req), 32'd0);
    $display("rst_req: reset applied during REQ, then ack");

    // Recovery: a normal op right after the abort
    run_op(vecs[0], "post_rst");

    // No ack at all: timeout build completes after 8 REQ cycles, default build waits
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h0000_0800;
    @(negedge clk);
    chk("noack bus_req", 32'(bus_req), 32'd1);
`ifdef MEM_TIMEOUT_EN
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout req_cycles", 32'(n - 1), 32'd8);
    chk("timeout err", 32'(err), 32'd1);
    chk("timeout rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("timeout bus_req", 32'(bus_req), 32'd0);
    req_valid = 1'b0;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("timeout late_ack", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("timeout late_ack2", 32'(rsp_valid), 32'd0);
    $display("noack: timed out after %0d REQ cycles", n - 1);
`else
    seen_rsp = 1'b0;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1'b1;
    end
    chk("noack no_rsp_by_100", 32'(seen_rsp), 32'd0);
    chk("noack bus_req_at_100", 32'(bus_req), 32'd1);
    chk("noack stall_at_100", 32'(stall), 32'd1);
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("noack bus_req_after_reset", 32'(bus_req), 32'd0);
    @(negedge clk);
    $display("noack: still waiting after 100 cycles, cleared by reset");
`endif

    // Random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      rv = make_vec(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 4)));
      run_op(rv, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
